ps2_command_tx: RTL and testbench

Host-to-device PS/2 transmitter: sends one 8-bit command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the attached keyboard over the shared open-drain ps2_clock/ps2_data lines. Sits beside the PS/2 receive path on the same two pins and drives them only while a transfer is in progress. Performs the bus inhibit, request-to-send, bit serialisation on device-generated clock edges, odd-parity generation, acknowledge check and timeouts.

---
 rtl/ps2_command_tx.sv | 243 ++++++++++++++++++++++++
 tb/tb_ps2_command_tx.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_command_tx.sv
// ps2_command_tx: host-to-device PS/2 transmitter. It sends one command byte
// to the attached device over the shared open-drain ps2_clock/ps2_data pins.
// The sequence is: inhibit, request-to-send, ten bits clocked out on
// device-generated falling edges, ACK bit, then wait for an idle bus.
// Optional build macro: PS2_TX_ACK_CHECK_EN. When it is defined, a high ACK
// bit is reported on error_no_ack instead of command_was_sent.
module ps2_command_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int BIT_TIMEOUT    = 100000,
  parameter int CNT_W          = 20
) (
  input  logic       inclock,
  input  logic       resetn,
  inout  wire        ps2_clock,
  inout  wire        ps2_data,
  input  logic [7:0] command,
  input  logic       send_command,
  output logic       busy,
  output logic       command_was_sent,
  output logic       error_timed_out,
  output logic       error_no_ack
);

  // The inhibit phase ends one cycle early because the REQ cycle also holds
  // the clock low. The total clock-low time is then exactly INHIBIT_CYCLES.
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] START_LIMIT  = CNT_W'(START_TIMEOUT);
  localparam logic [CNT_W-1:0] BIT_LIMIT    = CNT_W'(BIT_TIMEOUT);
  localparam logic [CNT_W-1:0] TIMER_MAX    = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_WAIT_FIRST,
    ST_SEND,
    ST_WAIT_ACK,
    ST_WAIT_IDLE,
    ST_TIMEOUT
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] timer_reg, timer_next;
  logic [3:0]       bit_cnt_reg, bit_cnt_next;
  logic [9:0]       shift_reg, shift_next;
  logic             clk_en_reg, clk_en_next;
  logic             data_en_reg, data_en_next;
  logic             busy_reg, busy_next;
  logic             sent_reg, sent_next;
  logic             timeout_reg, timeout_next;
`ifdef PS2_TX_ACK_CHECK_EN
  logic             ack_reg, ack_next;
  logic             no_ack_reg, no_ack_next;
`endif

  // Bit 0 of the pin and sync vectors is the clock line; bit 1 is the data line.
  wire  [1:0] pin_in = {ps2_data, ps2_clock};
  wire  [1:0] sync_line;
  logic       sync_clk_prev_reg;
  logic       sync_clk;
  logic       sync_data;
  logic       fall;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      // The two-flop synchroniser resets to the idle-high bus level, so reset cannot create a false falling edge.
      always_ff @(posedge inclock) begin
        if (!resetn) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
        end else begin
          meta_reg <= pin_in[gi];
          sync_reg <= meta_reg;
        end
      end
      assign sync_line[gi] = sync_reg;
    end
  endgenerate

  assign sync_clk  = sync_line[0];
  assign sync_data = sync_line[1];
  assign fall      = sync_clk_prev_reg & ~sync_clk;

  // The open-drain pins are driven only from registered enables. Each pin is either pulled low or released.
  assign ps2_clock = clk_en_reg  ? 1'b0 : 1'bz;
  assign ps2_data  = data_en_reg ? 1'b0 : 1'bz;

  assign busy             = busy_reg;
  assign command_was_sent = sent_reg;
  assign error_timed_out  = timeout_reg;
`ifdef PS2_TX_ACK_CHECK_EN
  assign error_no_ack     = no_ack_reg;
`else
  assign error_no_ack     = 1'b0;
`endif

  // State register and datapath registers. Reset overrides any transfer in progress.
  always_ff @(posedge inclock) begin
    if (!resetn) begin
      state_reg         <= ST_IDLE;
      timer_reg         <= '0;
      bit_cnt_reg       <= '0;
      shift_reg         <= '0;
      clk_en_reg        <= 1'b0;
      data_en_reg       <= 1'b0;
      busy_reg          <= 1'b0;
      sent_reg          <= 1'b0;
      timeout_reg       <= 1'b0;
      sync_clk_prev_reg <= 1'b1;
`ifdef PS2_TX_ACK_CHECK_EN
      ack_reg           <= 1'b0;
      no_ack_reg        <= 1'b0;
`endif
    end else begin
      state_reg         <= state_next;
      timer_reg         <= timer_next;
      bit_cnt_reg       <= bit_cnt_next;
      shift_reg         <= shift_next;
      clk_en_reg        <= clk_en_next;
      data_en_reg       <= data_en_next;
      busy_reg          <= busy_next;
      sent_reg          <= sent_next;
      timeout_reg       <= timeout_next;
      sync_clk_prev_reg <= sync_clk;
`ifdef PS2_TX_ACK_CHECK_EN
      ack_reg           <= ack_next;
      no_ack_reg        <= no_ack_next;
`endif
    end
  end

  // Next-state logic: sequencing, bit shifting, the saturating timer and the result pulses.
  always_comb begin
    state_next   = state_reg;
    timer_next   = (timer_reg == TIMER_MAX) ? timer_reg : timer_reg + 1'b1;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    clk_en_next  = clk_en_reg;
    data_en_next = data_en_reg;
    busy_next    = busy_reg;
    sent_next    = 1'b0;
    timeout_next = 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
    ack_next     = ack_reg;
    no_ack_next  = 1'b0;
`endif

    case (state_reg)
      ST_IDLE: begin
        timer_next   = '0;
        bit_cnt_next = '0;
        clk_en_next  = 1'b0;
        data_en_next = 1'b0;
        if (send_command) begin
          state_next  = ST_INHIBIT;
          shift_next  = {1'b1, ~^command, command};
          clk_en_next = 1'b1;
          busy_next   = 1'b1;
        end
      end
      ST_INHIBIT: begin
        if (timer_reg >= INHIBIT_LAST) begin
          state_next   = ST_REQ;
          data_en_next = 1'b1;
          timer_next   = '0;
        end
      end
      ST_REQ: begin
        state_next  = ST_WAIT_FIRST;
        clk_en_next = 1'b0;
        timer_next  = '0;
      end
      ST_WAIT_FIRST: begin
        if (fall) begin
          data_en_next = ~shift_reg[0];
          shift_next   = {1'b1, shift_reg[9:1]};
          bit_cnt_next = 4'd1;
          timer_next   = '0;
          state_next   = ST_SEND;
        end else if (timer_reg >= START_LIMIT) begin
          state_next = ST_TIMEOUT;
        end
      end
      ST_SEND: begin
        if (fall) begin
          // The stop bit is 1, so the tenth edge releases the data line.
          data_en_next = ~shift_reg[0];
          shift_next   = {1'b1, shift_reg[9:1]};
          bit_cnt_next = bit_cnt_reg + 4'd1;
          timer_next   = '0;
          if (bit_cnt_reg == 4'd9) state_next = ST_WAIT_ACK;
        end else if (timer_reg >= BIT_LIMIT) begin
          state_next = ST_TIMEOUT;
        end
      end
      ST_WAIT_ACK: begin
        if (fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
          ack_next     = sync_data;
`endif
          bit_cnt_next = bit_cnt_reg + 4'd1;
          timer_next   = '0;
          state_next   = ST_WAIT_IDLE;
        end else if (timer_reg >= BIT_LIMIT) begin
          state_next = ST_TIMEOUT;
        end
      end
      ST_WAIT_IDLE: begin
        if (sync_clk && sync_data) begin
          state_next = ST_IDLE;
          busy_next  = 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
          if (ack_reg) no_ack_next = 1'b1;
          else         sent_next   = 1'b1;
`else
          sent_next  = 1'b1;
`endif
        end else if (timer_reg >= BIT_LIMIT) begin
          state_next = ST_TIMEOUT;
        end
      end
      ST_TIMEOUT: begin
        clk_en_next  = 1'b0;
        data_en_next = 1'b0;
        timeout_next = 1'b1;
        busy_next    = 1'b0;
        state_next   = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Both lines are released as soon as a timeout is declared.
    if (state_next == ST_TIMEOUT) begin
      clk_en_next  = 1'b0;
      data_en_next = 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_command_tx.sv
// tb_ps2_command_tx: self-checking bench for ps2_command_tx. A device model
// clocks the bus at a 40-cycle period and acknowledges each transfer.
// Expected frames come from a byte-level model: LSB first, odd parity, stop bit.
module tb_ps2_command_tx;
  localparam int INHIBIT = 20;
  localparam int START   = 200;
  localparam int BITTO   = 100;
  localparam int HALF    = 20;

  logic       inclock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] command = 8'h00;
  logic       send_command = 1'b0;
  logic       busy, command_was_sent, error_timed_out, error_no_ack;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  wire        ps2_clock;
  wire        ps2_data;

  pullup (ps2_clock);
  pullup (ps2_data);
  assign ps2_clock = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2_data  = dev_data_low ? 1'b0 : 1'bz;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int sent_cnt = 0;
  int to_cnt = 0;
  int na_cnt = 0;
  int busy_low = 0;
  bit track_busy = 1'b0;

  always #5 inclock = ~inclock;

  ps2_command_tx #(
    .INHIBIT_CYCLES(INHIBIT),
    .START_TIMEOUT (START),
    .BIT_TIMEOUT   (BITTO),
    .CNT_W         (20)
  ) dut (
    .inclock         (inclock),
    .resetn          (resetn),
    .ps2_clock       (ps2_clock),
    .ps2_data        (ps2_data),
    .command         (command),
    .send_command    (send_command),
    .busy            (busy),
    .command_was_sent(command_was_sent),
    .error_timed_out (error_timed_out),
    .error_no_ack    (error_no_ack)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: summary not reached within time limit");
    $fatal(1, "watchdog expired");
  end

  // Wire-level frame of a command: data LSB first, odd parity, stop bit.
  function automatic logic [9:0] frame_of(input logic [7:0] c);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(c[i]);
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, c};
  endfunction

  // Advance to the next falling clock edge and log result pulses and busy gaps.
  task automatic tick();
    @(negedge inclock);
    cyc++;
    if (command_was_sent === 1'b1) sent_cnt++;
    if (error_timed_out === 1'b1) to_cnt++;
    if (error_no_ack === 1'b1) na_cnt++;
    if (track_busy) begin
      if (command_was_sent || error_timed_out || error_no_ack) track_busy = 1'b0;
      else if (busy !== 1'b1) busy_low++;
    end
  endtask

  task automatic start_send(input logic [7:0] c);
    command = c;
    send_command = 1'b1;
    busy_low = 0;
    tick();
    send_command = 1'b0;
    track_busy = 1'b1;
  endtask

  // Device model: measure the inhibit phase, then generate up to 11 clocks.
  // The data line is sampled as each clock rises. ACK is pulled low around the 11th edge.
  task automatic dev_run(input int edges, input bit ack_low, input int gap,
                         output logic [9:0] bits, output int low_len, output int req_len,
                         output logic start_bit, output int fall_cyc);
    int guard;
    guard = 0;
    bits = '1;
    low_len = 0;
    req_len = 0;
    fall_cyc = cyc;
    while (ps2_clock !== 1'b0 && guard < 50) begin
      tick();
      guard++;
    end
    while (ps2_clock === 1'b0 && low_len < 500) begin
      low_len++;
      if (ps2_data === 1'b0) req_len++;
      tick();
    end
    start_bit = ps2_data;
    repeat (gap) tick();
    for (int k = 1; k <= edges; k++) begin
      dev_clk_low = 1'b1;
      fall_cyc = cyc;
      repeat (HALF) tick();
      if (k <= 10) bits[k-1] = ps2_data;
      dev_clk_low = 1'b0;
      if (k == 10) begin
        repeat (HALF / 2) tick();
        dev_data_low = ack_low;
        repeat (HALF / 2) tick();
      end else if (k == 11) begin
        repeat (5) tick();
        dev_data_low = 1'b0;
        repeat (HALF - 5) tick();
      end else begin
        repeat (HALF) tick();
      end
    end
    dev_data_low = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (5) tick();
    vectors++;
    if ({busy, command_was_sent, error_timed_out, error_no_ack} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 0000", {busy, command_was_sent, error_timed_out, error_no_ack});
    end
    vectors++;
    if ({ps2_clock, ps2_data} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_lines: got %b want 11", {ps2_clock, ps2_data});
    end
    resetn = 1'b1;
    repeat (3) tick();
    vectors++;
    if ({busy, command_was_sent, error_timed_out, error_no_ack, ps2_clock, ps2_data} !== 6'b000011) begin
      miscompares++;
      $display("FAIL post_reset_idle: got %b want 000011",
               {busy, command_was_sent, error_timed_out, error_no_ack, ps2_clock, ps2_data});
    end
    $display("reset: outputs and lines checked");
  endtask

  task automatic test_send(input logic [7:0] c, input int gap);
    logic [9:0] exp_frame, got;
    logic       sb;
    int         lo, rq, fc, s0, t0, n0;
    exp_frame = frame_of(c);
    s0 = sent_cnt; t0 = to_cnt; n0 = na_cnt;
    start_send(c);
    dev_run(11, 1'b1, gap, got, lo, rq, sb, fc);
    repeat (20) tick();
    track_busy = 1'b0;
    vectors++;
    if (lo != INHIBIT) begin miscompares++; $display("FAIL inhibit_len cmd=%02h: got %0d want %0d", c, lo, INHIBIT); end
    vectors++;
    if (rq != 1) begin miscompares++; $display("FAIL req_overlap cmd=%02h: got %0d want 1", c, rq); end
    vectors++;
    if (sb !== 1'b0) begin miscompares++; $display("FAIL start_bit cmd=%02h: got %b want 0", c, sb); end
    vectors++;
    if (got !== exp_frame) begin miscompares++; $display("FAIL frame cmd=%02h: got %b want %b", c, got, exp_frame); end
    vectors++;
    if (sent_cnt - s0 != 1) begin miscompares++; $display("FAIL sent_pulses cmd=%02h: got %0d want 1", c, sent_cnt - s0); end
    vectors++;
    if ((to_cnt - t0) + (na_cnt - n0) != 0) begin
      miscompares++;
      $display("FAIL error_pulses cmd=%02h: got %0d want 0", c, (to_cnt - t0) + (na_cnt - n0));
    end
    vectors++;
    if (busy_low != 0) begin miscompares++; $display("FAIL busy_gap cmd=%02h: got %0d low cycles want 0", c, busy_low); end
    vectors++;
    if ({busy, ps2_clock, ps2_data} !== 3'b011) begin
      miscompares++;
      $display("FAIL end_idle cmd=%02h: got %b want 011", c, {busy, ps2_clock, ps2_data});
    end
    $display("send cmd=%02h frame=%b inhibit=%0d gap=%0d", c, got, lo, gap);
  endtask

  task automatic test_no_clock();
    logic [9:0] got;
    logic       sb;
    int         lo, rq, fc, t_rel, t0, s0, guard, delay;
    t0 = to_cnt; s0 = sent_cnt;
    start_send(8'h5A);
    dev_run(0, 1'b1, 0, got, lo, rq, sb, fc);
    t_rel = cyc;
    guard = 0;
    while (to_cnt == t0 && guard < 2 * START) begin tick(); guard++; end
    delay = cyc - t_rel;
    track_busy = 1'b0;
    vectors++;
    if (delay < START || delay > START + 4) begin
      miscompares++;
      $display("FAIL start_timeout_delay: got %0d want %0d..%0d", delay, START, START + 4);
    end
    tick();
    vectors++;
    if ({busy, ps2_clock, ps2_data} !== 3'b011) begin
      miscompares++;
      $display("FAIL start_timeout_release: got %b want 011", {busy, ps2_clock, ps2_data});
    end
    vectors++;
    if (sent_cnt != s0) begin miscompares++; $display("FAIL start_timeout_sent: got %0d want 0", sent_cnt - s0); end
    $display("no_clock: timeout after %0d cycles", delay);
  endtask

  task automatic test_stall();
    logic [9:0] exp_frame, got;
    logic       sb;
    int         lo, rq, fc, t0, s0, guard, delay;
    exp_frame = frame_of(8'hC3);
    t0 = to_cnt; s0 = sent_cnt;
    start_send(8'hC3);
    dev_run(4, 1'b1, 12, got, lo, rq, sb, fc);
    guard = 0;
    while (to_cnt == t0 && guard < 3 * BITTO) begin tick(); guard++; end
    delay = cyc - fc;
    track_busy = 1'b0;
    vectors++;
    if (got[3:0] !== exp_frame[3:0]) begin
      miscompares++;
      $display("FAIL stall_bits: got %b want %b", got[3:0], exp_frame[3:0]);
    end
    vectors++;
    if (delay < BITTO || delay > BITTO + 8) begin
      miscompares++;
      $display("FAIL bit_timeout_delay: got %0d want %0d..%0d", delay, BITTO, BITTO + 8);
    end
    tick();
    vectors++;
    if ({busy, ps2_clock, ps2_data, 1'(sent_cnt != s0)} !== 4'b0110) begin
      miscompares++;
      $display("FAIL bit_timeout_end: got %b want 0110", {busy, ps2_clock, ps2_data, 1'(sent_cnt != s0)});
    end
    $display("stall: timeout %0d cycles after last edge", delay);
  endtask

  task automatic test_no_ack();
    logic [9:0] got;
    logic       sb;
    int         lo, rq, fc, s0, n0, exp_sent, exp_na;
`ifdef PS2_TX_ACK_CHECK_EN
    exp_sent = 0; exp_na = 1;
`else
    exp_sent = 1; exp_na = 0;
`endif
    s0 = sent_cnt; n0 = na_cnt;
    start_send(8'hFF);
    dev_run(11, 1'b0, 20, got, lo, rq, sb, fc);
    repeat (20) tick();
    track_busy = 1'b0;
    vectors++;
    if (sent_cnt - s0 != exp_sent) begin
      miscompares++;
      $display("FAIL no_ack_sent: got %0d want %0d", sent_cnt - s0, exp_sent);
    end
    vectors++;
    if (na_cnt - n0 != exp_na) begin
      miscompares++;
      $display("FAIL no_ack_flag: got %0d want %0d", na_cnt - n0, exp_na);
    end
    $display("ack_high: sent=%0d no_ack=%0d", sent_cnt - s0, na_cnt - n0);
  endtask

  task automatic test_reset_mid();
    logic [9:0] got;
    logic       sb;
    int         lo, rq, fc, t0, clk_low_seen, busy_seen;
    // 0x5A has bit 2 = 0, so the data line is held low after the third edge.
    start_send(8'h5A);
    dev_run(3, 1'b1, 10, got, lo, rq, sb, fc);
    vectors++;
    if (ps2_data !== 1'b0) begin miscompares++; $display("FAIL mid_send_data: got %b want 0", ps2_data); end
    command = 8'h3C;
    send_command = 1'b1;
    repeat (3) tick();
    resetn = 1'b0;
    tick();
    track_busy = 1'b0;
    vectors++;
    if ({ps2_clock, ps2_data} !== 2'b11) begin
      miscompares++;
      $display("FAIL mid_reset_lines: got %b want 11", {ps2_clock, ps2_data});
    end
    vectors++;
    if ({busy, command_was_sent, error_timed_out, error_no_ack} !== 4'b0000) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got %b want 0000", {busy, command_was_sent, error_timed_out, error_no_ack});
    end
    send_command = 1'b0;
    tick();
    resetn = 1'b1;
    t0 = to_cnt;
    clk_low_seen = 0; busy_seen = 0;
    repeat (150) begin
      tick();
      if (ps2_clock !== 1'b1) clk_low_seen++;
      if (busy !== 1'b0) busy_seen++;
    end
    vectors++;
    if (clk_low_seen + busy_seen != 0) begin
      miscompares++;
      $display("FAIL no_replay: got clk_low=%0d busy=%0d want 0", clk_low_seen, busy_seen);
    end
    vectors++;
    if (to_cnt != t0) begin miscompares++; $display("FAIL stale_timeout: got %0d want 0", to_cnt - t0); end
    $display("reset_mid_send: lines released, request not replayed");
  endtask

  initial begin
    test_reset();
    test_send(8'hED, 10);
    test_send(8'h00, 30);
    test_send(8'h01, 5);
    for (int i = 0; i < 4; i++) test_send(8'($urandom_range(0, 255)), int'($urandom_range(3, 150)));
    test_no_clock();
    test_stall();
    test_no_ack();
    test_send(8'hFF, 40);
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
